reg_bank_4x16_wb: RTL and testbench

//  Four-entry x 16-bit register bank with a one-deep write staging register.
//  It consumes the 2-bit-selected 16-bit write path produced by the 1-to-4 word demux

---
 rtl/reg_bank_4x16_wb.sv | 92 +++++++++
 tb/tb_reg_bank_4x16_wb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_4x16_wb.sv
// Four-entry register bank with a one-deep write staging register.
// Reads forward from the stage so read-after-write is always coherent.
module reg_bank_4x16_wb #(
    parameter int              WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit              ZERO_R0   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [1:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             hold,
    output logic             wr_pending,
    input  logic [1:0]       rd_sel_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [1:0]       rd_sel_b,
    output logic [WIDTH-1:0] rd_data_b
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stg_state_t;

    stg_state_t       state;
    stg_state_t       state_nxt;
    logic [1:0]       stg_sel;
    logic [WIDTH-1:0] stg_data;
    logic [WIDTH-1:0] bank [4];
    logic             stg_vld;
    logic             accept;
    logic             commit;

    assign stg_vld    = (state == FULL);
    assign wr_ready   = !stg_vld || !hold;
    assign wr_pending = stg_vld;
    assign accept     = wr_valid && wr_ready;
    assign commit     = stg_vld && !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (commit && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_sel  <= 2'd0;
            stg_data <= '0;
        end else if (accept) begin
            stg_sel  <= wr_sel;
            stg_data <= wr_data;
        end
    end

    // With ZERO_R0 a write to R0 still drains the stage but leaves the bank alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                bank[i] <= RESET_VAL;
            end
        end else if (commit && !(ZERO_R0 && stg_sel == 2'd0)) begin
            bank[stg_sel] <= stg_data;
        end
    end

    always_comb begin
        rd_data_a = bank[rd_sel_a];
        if (stg_vld && stg_sel == rd_sel_a) rd_data_a = stg_data;
        if (ZERO_R0 && rd_sel_a == 2'd0) rd_data_a = '0;
    end

    always_comb begin
        rd_data_b = bank[rd_sel_b];
        if (stg_vld && stg_sel == rd_sel_b) rd_data_b = stg_data;
        if (ZERO_R0 && rd_sel_b == 2'd0) rd_data_b = '0;
    end

endmodule

// File: tb/tb_reg_bank_4x16_wb.sv
// Randomised and directed bench for reg_bank_4x16_wb against a queue-based model.
// Two instances share stimulus: ZERO_R0=0 (dut0) and ZERO_R0=1 (dut1).
module tb_reg_bank_4x16_wb;

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [1:0]  wr_sel = 2'd0;
    logic [15:0] wr_data = 16'h0;
    logic        hold = 1'b0;
    logic [1:0]  rd_sel_a = 2'd0;
    logic [1:0]  rd_sel_b = 2'd0;

    logic        rdy0, pnd0, rdy1, pnd1;
    logic [15:0] ra0, rb0, ra1, rb1;

    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_en = 1'b0;

    logic [15:0] mbank [4];
    wr_t         q[$];

    always #5 clk = ~clk;

    reg_bank_4x16_wb #(.WIDTH(16), .RESET_VAL(16'h0000), .ZERO_R0(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(rdy0),
        .wr_sel(wr_sel), .wr_data(wr_data),
        .hold(hold), .wr_pending(pnd0),
        .rd_sel_a(rd_sel_a), .rd_data_a(ra0),
        .rd_sel_b(rd_sel_b), .rd_data_b(rb0)
    );

    reg_bank_4x16_wb #(.WIDTH(16), .RESET_VAL(16'h0000), .ZERO_R0(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(rdy1),
        .wr_sel(wr_sel), .wr_data(wr_data),
        .hold(hold), .wr_pending(pnd1),
        .rd_sel_a(rd_sel_a), .rd_data_a(ra1),
        .rd_sel_b(rd_sel_b), .rd_data_b(rb1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] m_rd(input logic [1:0] s);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].sel == s) return q[i].data;
        end
        return mbank[s];
    endfunction

    function automatic logic [15:0] m_rd_z(input logic [1:0] s);
        return (s == 2'd0) ? 16'h0000 : m_rd(s);
    endfunction

    function automatic logic m_ready();
        return (q.size() == 0) || !hold;
    endfunction

    // Behavioural model: pending writes in a queue, bank as a plain array.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 4; i++) mbank[i] = 16'h0000;
        end else begin
            bit acc;
            wr_t w;
            acc = wr_valid && m_ready();
            if (q.size() != 0 && !hold) begin
                mbank[q[0].sel] = q[0].data;
                void'(q.pop_front());
            end
            if (acc) begin
                w.sel  = wr_sel;
                w.data = wr_data;
                q.push_back(w);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("ready0", {15'd0, rdy0}, {15'd0, m_ready()});
            chk("pending0", {15'd0, pnd0}, {15'd0, q.size() != 0});
            chk("rd_a0", ra0, m_rd(rd_sel_a));
            chk("rd_b0", rb0, m_rd(rd_sel_b));
            chk("ready1", {15'd0, rdy1}, {15'd0, m_ready()});
            chk("pending1", {15'd0, pnd1}, {15'd0, q.size() != 0});
            chk("rd_a1", ra1, m_rd_z(rd_sel_a));
            chk("rd_b1", rb1, m_rd_z(rd_sel_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] s, input logic [15:0] d);
        wr_valid = 1'b1;
        wr_sel   = s;
        wr_data  = d;
    endtask

    initial begin
        logic [15:0] sdata [4];
        sdata[0] = 16'h0011;
        sdata[1] = 16'h2233;
        sdata[2] = 16'h4455;
        sdata[3] = 16'h6677;

        repeat (2) tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();
        chk("reset_rd", ra0, 16'h0000);
        chk("reset_ready", {15'd0, rdy0}, 16'h0001);

        // single write with forwarding then commit
        wr(2'd2, 16'hA5A5);
        rd_sel_a = 2'd2;
        tick();
        wr_valid = 1'b0;
        chk("fwd_a5", ra0, 16'hA5A5);
        chk("fwd_pnd", {15'd0, pnd0}, 16'h0001);
        tick();
        chk("commit_a5", ra0, 16'hA5A5);
        chk("commit_pnd", {15'd0, pnd0}, 16'h0000);

        // hold keeps the write staged but readable
        hold = 1'b1;
        rd_sel_b = 2'd1;
        wr(2'd1, 16'h1234);
        tick();
        wr_valid = 1'b0;
        chk("hold_pnd", {15'd0, pnd0}, 16'h0001);
        chk("hold_rdy", {15'd0, rdy0}, 16'h0000);
        chk("hold_fwd", rb0, 16'h1234);
        tick();
        chk("hold_pnd2", {15'd0, pnd0}, 16'h0001);
        hold = 1'b0;
        #1;
        chk("release_rdy", {15'd0, rdy0}, 16'h0001);
        tick();
        chk("release_pnd", {15'd0, pnd0}, 16'h0000);
        chk("release_rd", rb0, 16'h1234);

        // streaming one write per cycle
        for (int i = 0; i < 4; i++) begin
            wr(2'(i), sdata[i]);
            #1;
            chk("stream_rdy", {15'd0, rdy0}, 16'h0001);
            tick();
        end
        wr_valid = 1'b0;
        tick();
        chk("stream_pnd", {15'd0, pnd0}, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            rd_sel_a = 2'(i);
            #1;
            chk("stream_rd", ra0, sdata[i]);
        end
        rd_sel_a = 2'd0;
        #1;
        chk("z_stream_r0", ra1, 16'h0000);

        // same index back to back: last one wins
        rd_sel_a = 2'd3;
        wr(2'd3, 16'hAAAA);
        tick();
        chk("same_first", ra0, 16'hAAAA);
        wr(2'd3, 16'hBBBB);
        tick();
        wr_valid = 1'b0;
        chk("same_second", ra0, 16'hBBBB);
        tick();
        chk("same_final", ra0, 16'hBBBB);

        // write to R0 on both instances
        rd_sel_a = 2'd0;
        rd_sel_b = 2'd1;
        wr(2'd0, 16'hFFFF);
        tick();
        wr_valid = 1'b0;
        chk("z_pnd", {15'd0, pnd1}, 16'h0001);
        chk("z_rd0_stg", ra1, 16'h0000);
        chk("nz_rd0_stg", ra0, 16'hFFFF);
        tick();
        chk("z_rd0_bank", ra1, 16'h0000);
        chk("nz_rd0_bank", ra0, 16'hFFFF);
        chk("z_rd1", rb1, 16'h2233);

        // asynchronous reset with a write still staged
        hold = 1'b1;
        rd_sel_a = 2'd2;
        wr(2'd2, 16'h5A5A);
        tick();
        wr_valid = 1'b0;
        chk("pre_rst_fwd", ra0, 16'h5A5A);
        rst_n = 1'b0;
        #1;
        chk("rst_rd", ra0, 16'h0000);
        chk("rst_pnd", {15'd0, pnd0}, 16'h0000);
        chk("rst_rdy", {15'd0, rdy0}, 16'h0001);
        hold = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_discard", ra0, 16'h0000);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_sel   = 2'($urandom_range(0, 3));
            wr_data  = 16'($urandom);
            hold     = ($urandom_range(0, 3) == 0);
            rd_sel_a = 2'($urandom_range(0, 3));
            rd_sel_b = 2'($urandom_range(0, 3));
            tick();
        end

        wr_valid = 1'b0;
        hold = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
